// File: rtl/toggle_monitor_if.sv
// Measurement bus for toggle_monitor: control/sample inputs and report outputs.
// TOGGLE_MONITOR_SPLIT_EN adds the rise/fall count signals.
interface toggle_monitor_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             en;
  logic             din;
  logic [WIN_W-1:0] window;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             overflow;
  logic             busy;
`ifdef TOGGLE_MONITOR_SPLIT_EN
  logic [CNT_W-1:0] rise_count;
  logic [CNT_W-1:0] fall_count;

  modport master (output en, din, window,
                  input  count, count_valid, overflow, busy, rise_count, fall_count);
  modport slave  (input  en, din, window,
                  output count, count_valid, overflow, busy, rise_count, fall_count);
`else
  modport master (output en, din, window,
                  input  count, count_valid, overflow, busy);
  modport slave  (input  en, din, window,
                  output count, count_valid, overflow, busy);
`endif
endinterface

// File: rtl/toggle_monitor.sv
// Counts transitions of a single-bit net over back-to-back windows of clock cycles.
// Define TOGGLE_MONITOR_SPLIT_EN to also report separate rise and fall counts.
module toggle_monitor #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  toggle_monitor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

  state_t           r_state;
  logic             r_prev;
  logic             r_sat;
  logic             r_busy;
  logic             r_count_valid;
  logic             r_overflow;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [WIN_W-1:0] r_win_cnt;

  logic             w_t;
  logic             w_acc_max;
  logic             w_sat_now;
  logic             w_ovf;
  logic             w_last;
  logic             w_win_ok;
  logic [WIN_W-1:0] w_win_m1;
  logic [CNT_W-1:0] w_acc_nxt;

  assign w_t       = bus.din ^ r_prev;
  assign w_acc_max = &r_acc;
  assign w_sat_now = w_t & w_acc_max;
  assign w_acc_nxt = (w_t && !w_acc_max) ? r_acc + CNT_W'(1) : r_acc;
  assign w_last    = (r_win_cnt == '0);
  assign w_win_ok  = (bus.window != '0);
  assign w_win_m1  = bus.window - WIN_W'(1);

`ifdef TOGGLE_MONITOR_SPLIT_EN
  logic             r_rsat, r_fsat;
  logic [CNT_W-1:0] r_racc, r_facc, r_rise_count, r_fall_count;
  logic             w_r, w_f, w_rsat_now, w_fsat_now;
  logic [CNT_W-1:0] w_racc_nxt, w_facc_nxt;

  assign w_r        = w_t & bus.din;
  assign w_f        = w_t & ~bus.din;
  assign w_rsat_now = w_r & (&r_racc);
  assign w_fsat_now = w_f & (&r_facc);
  assign w_racc_nxt = (w_r && !(&r_racc)) ? r_racc + CNT_W'(1) : r_racc;
  assign w_facc_nxt = (w_f && !(&r_facc)) ? r_facc + CNT_W'(1) : r_facc;
  assign w_ovf      = r_sat | w_sat_now | r_rsat | w_rsat_now | r_fsat | w_fsat_now;

  assign bus.rise_count = r_rise_count;
  assign bus.fall_count = r_fall_count;
`else
  assign w_ovf = r_sat | w_sat_now;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_prev        <= 1'b0;
      r_sat         <= 1'b0;
      r_busy        <= 1'b0;
      r_count_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_acc         <= '0;
      r_count       <= '0;
      r_win_cnt     <= '0;
`ifdef TOGGLE_MONITOR_SPLIT_EN
      r_rsat        <= 1'b0;
      r_fsat        <= 1'b0;
      r_racc        <= '0;
      r_facc        <= '0;
      r_rise_count  <= '0;
      r_fall_count  <= '0;
`endif
    end else begin
      r_count_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.en && w_win_ok) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
          end
        end
        ARM: begin
          r_prev    <= bus.din;
          r_acc     <= '0;
          r_sat     <= 1'b0;
          r_win_cnt <= w_win_m1;
          r_state   <= RUN;
`ifdef TOGGLE_MONITOR_SPLIT_EN
          r_racc    <= '0;
          r_facc    <= '0;
          r_rsat    <= 1'b0;
          r_fsat    <= 1'b0;
`endif
        end
        RUN: begin
          r_prev <= bus.din;
          if (w_last) begin
            // Report includes this cycle's toggle; reload keeps prev so windows are gapless.
            r_count       <= w_acc_nxt;
            r_overflow    <= w_ovf;
            r_count_valid <= 1'b1;
            r_acc         <= '0;
            r_sat         <= 1'b0;
`ifdef TOGGLE_MONITOR_SPLIT_EN
            r_rise_count  <= w_racc_nxt;
            r_fall_count  <= w_facc_nxt;
            r_racc        <= '0;
            r_facc        <= '0;
            r_rsat        <= 1'b0;
            r_fsat        <= 1'b0;
`endif
            if (bus.en && w_win_ok) begin
              r_win_cnt <= w_win_m1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (!bus.en) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc     <= w_acc_nxt;
            r_sat     <= r_sat | w_sat_now;
            r_win_cnt <= r_win_cnt - WIN_W'(1);
`ifdef TOGGLE_MONITOR_SPLIT_EN
            r_racc    <= w_racc_nxt;
            r_facc    <= w_facc_nxt;
            r_rsat    <= r_rsat | w_rsat_now;
            r_fsat    <= r_fsat | w_fsat_now;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count       = r_count;
  assign bus.count_valid = r_count_valid;
  assign bus.overflow    = r_overflow;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboard bench for toggle_monitor: a 16-bit instance for the main tests and a
// 3-bit instance for saturation; a monitor pops expected reports on each count_valid.
module tb_toggle_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toggle_monitor_if #(.CNT_W(16), .WIN_W(16)) m_if ();
  toggle_monitor_if #(.CNT_W(3),  .WIN_W(16)) s_if ();

  toggle_monitor #(.CNT_W(16), .WIN_W(16)) dut  (.clk(clk), .rst(rst), .bus(m_if.slave));
  toggle_monitor #(.CNT_W(3),  .WIN_W(16)) dut3 (.clk(clk), .rst(rst), .bus(s_if.slave));

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
    logic [15:0] rise;
    logic [15:0] fall;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];
  int   vt[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input int c, input bit o, input int r, input int f);
    exp_t e;
    e.cnt = 16'(c); e.ovf = o; e.rise = 16'(r); e.fall = 16'(f);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One call drives the inputs seen by the next rising edge; the idle instance sits with en=0.
  task automatic tick(input bit sel, input bit e, input bit d, input int w);
    @(negedge clk);
    if (sel) begin
      s_if.en = e; s_if.din = d; s_if.window = 16'(w);
      m_if.en = 1'b0;
    end else begin
      m_if.en = e; m_if.din = d; m_if.window = 16'(w);
      s_if.en = 1'b0;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (m_if.count_valid === 1'b1) begin
      vt.push_back(cyc);
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_valid: count=%0d with no report expected", m_if.count);
      end else begin
        e = q.pop_front();
        chk("count", m_if.count, e.cnt);
        chk("overflow", 16'(m_if.overflow), 16'(e.ovf));
`ifdef TOGGLE_MONITOR_SPLIT_EN
        chk("rise_count", m_if.rise_count, e.rise);
        chk("fall_count", m_if.fall_count, e.fall);
`endif
      end
    end
    if (s_if.count_valid === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_valid3: count=%0d with no report expected", s_if.count);
      end else begin
        e = q3.pop_front();
        chk("count3", 16'(s_if.count), e.cnt);
        chk("overflow3", 16'(s_if.overflow), 16'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_if.en = 0; m_if.din = 0; m_if.window = 0;
    s_if.en = 0; s_if.din = 0; s_if.window = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", m_if.count, 16'd0);
    chk("rst_valid", 16'(m_if.count_valid), 16'd0);
    chk("rst_busy", 16'(m_if.busy), 16'd0);
    chk("rst_overflow", 16'(m_if.overflow), 16'd0);
    rst = 1'b0;
    tick(0, 0, 0, 0);

    // Alternating din, window 8: two gapless reports of 8, then abort the third window
    vt.delete();
    q.push_back(mk(8, 0, 4, 4));
    q.push_back(mk(8, 0, 4, 4));
    for (int i = 0; i < 18; i++) tick(0, 1, bit'(i & 1), 8);
    tick(0, 0, 0, 8);
    repeat (3) tick(0, 0, 0, 8);
    chk("valid_pulses", 16'(vt.size()), 16'd2);
    chk("report_gap", (vt.size() == 2) ? 16'(vt[1] - vt[0]) : 16'hFFFF, 16'd8);

    // Constant din: no toggles
    q.push_back(mk(0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 4);
    tick(0, 0, 1, 4);
    repeat (2) tick(0, 0, 1, 0);

    // Single rising step exactly on the last RUN cycle
    q.push_back(mk(1, 0, 1, 0));
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 4);
    tick(0, 0, 1, 4);
    repeat (2) tick(0, 0, 1, 0);

    // 3-bit instance: 12 toggles saturate at 7, next window of 2 toggles clears overflow
    q3.push_back(mk(7, 1, 0, 0));
    q3.push_back(mk(2, 0, 0, 0));
    for (int i = 0; i < 26; i++)
      tick(1, (i != 25), (i < 14) ? bit'(i & 1) : (i != 14), 12);
    repeat (2) tick(0, 0, 0, 0);

    // Abort after 3 RUN cycles: no report, previous count (1) kept
    tick(0, 1, 0, 10);
    tick(0, 1, 0, 10);
    tick(0, 1, 1, 10);
    tick(0, 1, 0, 10);
    tick(0, 1, 1, 10);
    tick(0, 0, 0, 10);
    @(posedge clk); #1;
    chk("abort_busy", 16'(m_if.busy), 16'd0);
    chk("abort_count", m_if.count, 16'd1);
    chk("abort_overflow", 16'(m_if.overflow), 16'd0);

    // Zero window never leaves IDLE
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, bit'(i & 1), 0);
      @(posedge clk); #1;
      chk("zero_win_busy", 16'(m_if.busy), 16'd0);
    end

`ifdef TOGGLE_MONITOR_SPLIT_EN
    // Pattern 0 | 1,1,0,1,0,0 -> 2 rises, 2 falls
    q.push_back(mk(4, 0, 2, 2));
    tick(0, 1, 0, 6);
    tick(0, 1, 0, 6);
    tick(0, 1, 1, 6);
    tick(0, 1, 1, 6);
    tick(0, 1, 0, 6);
    tick(0, 1, 1, 6);
    tick(0, 1, 0, 6);
    tick(0, 0, 0, 6);
    repeat (2) tick(0, 0, 0, 0);
`endif

    // Reset mid-window with acc=5: nothing reported, outputs back to reset values
    tick(0, 1, 0, 16);
    tick(0, 1, 0, 16);
    tick(0, 1, 1, 16);
    tick(0, 1, 0, 16);
    tick(0, 1, 1, 16);
    tick(0, 1, 0, 16);
    tick(0, 1, 1, 16);
    @(negedge clk);
    rst = 1'b1; m_if.en = 1'b0;
    #1;
    chk("midrst_count", m_if.count, 16'd0);
    chk("midrst_valid", 16'(m_if.count_valid), 16'd0);
    chk("midrst_busy", 16'(m_if.busy), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(0, 0, 0, 0);
    @(posedge clk); #1;
    chk("post_rst_busy", 16'(m_if.busy), 16'd0);
    repeat (2) tick(0, 0, 0, 0);

    chk("q_drained", 16'(q.size()), 16'd0);
    chk("q3_drained", 16'(q3.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
